bcd_down_digit: RTL and testbench

- Single-digit modulo-(MAX_VAL+1) down counter, 4-bit, default 0..9. Forms one digit stage of a cascaded countdown timer.
- Supports parallel load of a start value.
- Reloads a programmable value on underflow, so a higher digit can wrap to 5 or 9, for example.
- Emits an active-low ripple-carry/borrow to enable the next stage.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/bcd_down_digit_range_sel.sv | 50 +++++
 rtl/bcd_down_digit.sv | 88 ++++++++
 tb/tb_bcd_down_digit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the countdown-timer digit stages:
//               default digit width, default largest count, digit type and
//               the zero digit constant.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Default width of one digit stage
    localparam int TIMER_WIDTH   = 4;

    // Default largest legal count in one digit stage (decimal digit)
    localparam int TIMER_MAX_VAL = 9;

    // One BCD digit at the default width
    typedef logic [TIMER_WIDTH-1:0] digit_t;

    // Digit value reached by reset and by counting down to the bottom
    localparam digit_t DIGIT_ZERO = digit_t'(0);

endpackage : timer_pkg
`default_nettype wire

// File: rtl/bcd_down_digit_range_sel.sv
`default_nettype none
// ============================================================================
// Module      : bcd_range_sel
// Description : Combinational legality filter for a candidate digit value.
//               Returns the value the counter may take plus a flag telling
//               whether the counter should take it at all.
//               Build option: BCD_DOWN_DIGIT_CLAMP_EN - when defined, any
//               out-of-range candidate is clamped to MAX_VAL. When undefined,
//               the reload path clamps and the load path reports invalid so
//               the counter holds.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_range_sel
    import timer_pkg::*;
#(
    parameter int WIDTH     = TIMER_WIDTH,
    parameter int MAX_VAL   = TIMER_MAX_VAL,
    parameter bit IS_RELOAD = 1'b0
) (
    input  logic [WIDTH-1:0] i_cand,
    output logic [WIDTH-1:0] o_value,
    output logic             o_valid
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);

`ifdef BCD_DOWN_DIGIT_CLAMP_EN
    localparam bit c_clamp_all = 1'b1;
`else
    localparam bit c_clamp_all = 1'b0;
`endif

    // Candidate lies above the largest legal digit
    logic w_over;
    assign w_over = (i_cand > c_max);

    generate
        if (c_clamp_all || IS_RELOAD) begin : g_clamp
            // Out-of-range values saturate to the top digit and are always taken
            assign o_value = w_over ? c_max : i_cand;
            assign o_valid = 1'b1;
        end else begin : g_reject
            // Out-of-range values are refused so the counter keeps its state
            assign o_value = i_cand;
            assign o_valid = ~w_over;
        end
    endgenerate

endmodule : bcd_range_sel
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : One digit stage of a cascaded countdown timer. Counts down
//               from MAX_VAL to 0, reloads next_count_state on underflow,
//               supports synchronous parallel load and produces an active-low
//               ripple borrow (rco_L) that enables the next stage.
//               Build option: BCD_DOWN_DIGIT_CLAMP_EN selects clamping of
//               out-of-range loads (see bcd_range_sel).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int WIDTH   = TIMER_WIDTH,
    parameter int MAX_VAL = TIMER_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enablen,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] next_count_state,
    output logic [WIDTH-1:0] count,
    output logic             rco_L
);

    localparam logic [WIDTH-1:0] c_zero = WIDTH'(DIGIT_ZERO);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_load_val;
    logic             w_load_valid;
    logic [WIDTH-1:0] w_reload_val;
    logic             w_reload_valid;
    logic             w_at_zero;

    // Legalise the parallel-load value
    bcd_range_sel #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAX_VAL),
        .IS_RELOAD (1'b0)
    ) u_load_sel (
        .i_cand  (in),
        .o_value (w_load_val),
        .o_valid (w_load_valid)
    );

    // Legalise the underflow reload value
    bcd_range_sel #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAX_VAL),
        .IS_RELOAD (1'b1)
    ) u_reload_sel (
        .i_cand  (next_count_state),
        .o_value (w_reload_val),
        .o_valid (w_reload_valid)
    );

    assign w_at_zero = (r_count == c_zero);

    // Digit register: reset > load > count > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_zero;
        end else if (load) begin
            if (w_load_valid) begin
                r_count <= w_load_val;
            end
        end else if (!enablen) begin
            if (w_at_zero) begin
                // Zero never decrements, so the digit cannot wrap through all-ones
                if (w_reload_valid) begin
                    r_count <= w_reload_val;
                end
            end else begin
                r_count <= r_count - c_one;
            end
        end
    end

    assign count = r_count;

    // Borrow to the next stage while this digit sits at zero and is enabled
    assign rco_L = ~(w_at_zero & ~enablen);

endmodule : bcd_down_digit
`default_nettype wire

// File: tb/tb_bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_down_digit
// Description : Self-checking bench for bcd_down_digit. Stimulus pushes the
//               hand-computed expected count/rco_L for each cycle into a
//               queue; an independent monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_down_digit;

    typedef struct {
        bit         chk;
        logic [3:0] cnt;
        logic       rco;
        int         step;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       enablen;
    logic       load;
    logic [3:0] in;
    logic [3:0] next_count_state;
    logic [3:0] count;
    logic       rco_L;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;
    bit   stim_done = 1'b0;

`ifdef BCD_DOWN_DIGIT_CLAMP_EN
    localparam logic [3:0] c_oor_load = 4'd9;
`else
    localparam logic [3:0] c_oor_load = 4'd4;
`endif

    bcd_down_digit dut (
        .clk              (clk),
        .rst              (rst),
        .enablen          (enablen),
        .load             (load),
        .in               (in),
        .next_count_state (next_count_state),
        .count            (count),
        .rco_L            (rco_L)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue what the
    // DUT must show during this cycle (count from the previous edge, rco_L
    // from that count and the enablen now applied).
    task automatic apply(input bit r, input bit ld, input logic [3:0] d,
                         input logic [3:0] ncs, input bit en_n,
                         input bit chk, input logic [3:0] e_cnt, input bit e_rco);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        load             = ld;
        in               = d;
        next_count_state = ncs;
        enablen          = en_n;
        step_no++;
        e.chk  = chk;
        e.cnt  = e_cnt;
        e.rco  = e_rco;
        e.step = step_no;
        exp_q.push_back(e);
    endtask

    // Monitor: compare on the falling edge whenever an expectation is pending
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (count === e.cnt && rco_L === e.rco) begin
                        n_pass++;
                    end else begin
                        $display("FAIL step%0d count/rco_L: got %0d/%b expected %0d/%b",
                                 e.step, count, rco_L, e.cnt, e.rco);
                    end
                end
            end
        end
    end

    // Stimulus: directed vectors
    initial begin
        int wait_cycles;
        rst = 1'b1; load = 1'b0; in = 4'd0; next_count_state = 4'd0; enablen = 1'b1;

        // Reset for two edges, then enablen low drives rco_L low at once
        apply(1, 0, 4'd0, 4'd0, 1, 0, 4'd0, 1'b1);
        apply(1, 0, 4'd0, 4'd0, 1, 1, 4'd0, 1'b1);
        apply(0, 0, 4'd0, 4'd0, 0, 1, 4'd0, 1'b0);

        // Load 9 and count down to 0
        apply(0, 1, 4'd9, 4'd9, 1, 1, 4'd0, 1'b1);
        for (int k = 9; k >= 1; k--) begin
            apply(0, 0, 4'd0, 4'd9, 0, 1, 4'(k), 1'b1);
        end

        // Underflow reload to 9, then to 5
        apply(0, 0, 4'd0, 4'd9, 0, 1, 4'd0, 1'b0);
        apply(0, 1, 4'd0, 4'd9, 1, 1, 4'd9, 1'b1);
        apply(0, 0, 4'd0, 4'd5, 0, 1, 4'd0, 1'b0);

        // Hold at 7 for five edges
        apply(0, 1, 4'd7, 4'd9, 1, 1, 4'd5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 4'd0, 4'd9, 1, 1, 4'd7, 1'b1);
        end

        // Load beats underflow reload at zero; rco_L still low that cycle
        apply(0, 1, 4'd0, 4'd9, 1, 1, 4'd7, 1'b1);
        apply(0, 1, 4'd3, 4'd9, 0, 1, 4'd0, 1'b0);

        // Reset beats load
        apply(1, 1, 4'd6, 4'd9, 1, 1, 4'd3, 1'b1);

        // Out-of-range load: clamped to 9 or ignored
        apply(0, 1, 4'd4, 4'd9, 1, 1, 4'd0, 1'b1);
        apply(0, 1, 4'd12, 4'd9, 1, 1, 4'd4, 1'b1);

        // Out-of-range reload: 9 in either build
        apply(0, 1, 4'd0, 4'd15, 1, 1, c_oor_load, 1'b1);
        apply(0, 0, 4'd0, 4'd15, 0, 1, 4'd0, 1'b0);

        // Zero reload keeps digit at 0 with rco_L low
        apply(0, 1, 4'd0, 4'd0, 1, 1, 4'd9, 1'b1);
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 4'd0, 4'd0, 0, 1, 4'd0, 1'b0);
        end
        apply(0, 0, 4'd0, 4'd0, 1, 1, 4'd0, 1'b1);

        // Let the monitor drain, bounded
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog: stimulus did not complete, got timeout required completion");
            $fatal(1, "watchdog expired");
        end
    end

endmodule : tb_bcd_down_digit
`default_nettype wire
